// File: rtl/mul_seq_pkg.sv
// Shared definitions for the pip1 ALU multi-cycle units (multiplier and divider).
package mul_seq_pkg;

  localparam int W_PD_DATA = 32;
  localparam int W_PD_UOPS = 6;

  // Multiplier uops
  localparam logic [W_PD_UOPS-1:0] UOP_MUL    = 6'b000000;
  localparam logic [W_PD_UOPS-1:0] UOP_MULH   = 6'b000001;
  localparam logic [W_PD_UOPS-1:0] UOP_MULHSU = 6'b000010;
  localparam logic [W_PD_UOPS-1:0] UOP_MULHU  = 6'b000011;

  // Divider uops
  localparam logic [W_PD_UOPS-1:0] UOP_DIV    = 6'b000100;
  localparam logic [W_PD_UOPS-1:0] UOP_DIVU   = 6'b000101;
  localparam logic [W_PD_UOPS-1:0] UOP_REM    = 6'b000110;
  localparam logic [W_PD_UOPS-1:0] UOP_REMU   = 6'b000111;

  // Control state shared by both multi-cycle units
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_MUL  = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  // Two's-complement magnitude; 0x80000000 correctly maps to unsigned 2^31
  function automatic logic [W_PD_DATA-1:0] magnitude(input logic [W_PD_DATA-1:0] x,
                                                     input logic             isSigned);
    return (isSigned && x[W_PD_DATA-1]) ? (~x + W_PD_DATA'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Dataflow/controlflow bundle between the pipeline controller and the multiplier.
interface mul_seq_if;
  import mul_seq_pkg::*;

  logic [W_PD_UOPS-1:0] DFI_PD_uops;
  logic [W_PD_DATA-1:0] DFI_PD_rs;
  logic [W_PD_DATA-1:0] DFI_PD_rt;
  logic                 CFI_PC_ena;
  logic                 CFI_PC_clear;
  logic [W_PD_DATA-1:0] DFO_PD_rs;
  logic                 DFO_PD_ofw;
  logic                 CFO_PC_busy;
  logic                 CFO_PC_done;

  // Pipeline side: issues operations, observes results
  modport master (
    output DFI_PD_uops, DFI_PD_rs, DFI_PD_rt, CFI_PC_ena, CFI_PC_clear,
    input  DFO_PD_rs, DFO_PD_ofw, CFO_PC_busy, CFO_PC_done
  );

  // Execution unit side
  modport slave (
    input  DFI_PD_uops, DFI_PD_rs, DFI_PD_rt, CFI_PC_ena, CFI_PC_clear,
    output DFO_PD_rs, DFO_PD_ofw, CFO_PC_busy, CFO_PC_done
  );

endinterface

// File: rtl/mul_seq_step.sv
// One shift-add iteration on {ACC,MQ}: conditionally add M, then shift right by one.
module mul_step
  import mul_seq_pkg::*;
(
  input  logic [W_PD_DATA:0]   i_acc,
  input  logic [W_PD_DATA-1:0] i_mq,
  input  logic [W_PD_DATA-1:0] i_m,
  output logic [W_PD_DATA:0]   o_acc,
  output logic [W_PD_DATA-1:0] o_mq
);

  logic [W_PD_DATA:0] w_sum;

  // Add the multiplicand when the current multiplier bit is set, then shift the pair
  always_comb begin
    w_sum = i_mq[0] ? (i_acc + {1'b0, i_m}) : i_acc;
    o_acc = {1'b0, w_sum[W_PD_DATA:1]};
    o_mq  = {w_sum[0], i_mq[W_PD_DATA-1:1]};
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32-iteration shift-add multiplier for the pip1 ALU (low/high product words).
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  mul_seq_if.slave bus
);

  localparam int              W_CNT    = $clog2(W_PD_DATA);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_PD_DATA - 1);

  state_t                 r_state;
  logic [W_PD_UOPS-1:0]   r_uop;
  logic [W_PD_DATA-1:0]   r_rs;
  logic [W_PD_DATA-1:0]   r_rt;
  logic [W_PD_DATA:0]     r_acc;
  logic [W_PD_DATA-1:0]   r_mq;
  logic [W_PD_DATA-1:0]   r_m;
  logic                   r_sgn;
  logic [W_CNT-1:0]       r_cnt;
  logic [W_PD_DATA-1:0]   r_res;
  logic                   r_ofw;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_rsSigned;
  logic                   w_rtSigned;
  logic [W_PD_DATA:0]     w_accNext;
  logic [W_PD_DATA-1:0]   w_mqNext;
  logic [2*W_PD_DATA-1:0] w_prod;
  logic [W_PD_DATA-1:0]   w_res;
  logic                   w_ofw;

  mul_step u_step (
    .i_acc (r_acc),
    .i_mq  (r_mq),
    .i_m   (r_m),
    .o_acc (w_accNext),
    .o_mq  (w_mqNext)
  );

  // Decode operand signedness and form the signed final product and result word
  always_comb begin
    w_rsSigned = (r_uop == UOP_MUL) || (r_uop == UOP_MULH) || (r_uop == UOP_MULHSU);
    w_rtSigned = (r_uop == UOP_MUL) || (r_uop == UOP_MULH);
    w_prod     = {r_acc[W_PD_DATA-1:0], r_mq};
    if (r_sgn) begin
      w_prod = ~w_prod + (2*W_PD_DATA)'(1);
    end
    w_res = '0;
    w_ofw = 1'b0;
    case (r_uop)
      UOP_MUL: begin
        w_res = w_prod[W_PD_DATA-1:0];
        w_ofw = (w_prod[2*W_PD_DATA-1:W_PD_DATA] != {W_PD_DATA{w_prod[W_PD_DATA-1]}});
      end
      UOP_MULH, UOP_MULHSU, UOP_MULHU: begin
        w_res = w_prod[2*W_PD_DATA-1:W_PD_DATA];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // Control FSM with registered result, busy and done outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_uop   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_m     <= '0;
      r_sgn   <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_ofw   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.CFI_PC_clear) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.CFI_PC_ena) begin
              r_uop   <= bus.DFI_PD_uops;
              r_rs    <= bus.DFI_PD_rs;
              r_rt    <= bus.DFI_PD_rt;
              r_state <= ST_PREP;
              r_busy  <= 1'b1;
            end
          end
          ST_PREP: begin
            r_m     <= magnitude(r_rs, w_rsSigned);
            r_mq    <= magnitude(r_rt, w_rtSigned);
            r_sgn   <= (w_rsSigned & r_rs[W_PD_DATA-1]) ^ (w_rtSigned & r_rt[W_PD_DATA-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_MUL;
          end
          ST_MUL: begin
            r_acc <= w_accNext;
            r_mq  <= w_mqNext;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_FIN;
            end else begin
              r_cnt <= r_cnt + W_CNT'(1);
            end
          end
          ST_FIN: begin
            r_res   <= w_res;
            r_ofw   <= w_ofw;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DFO_PD_rs   = r_res;
  assign bus.DFO_PD_ofw  = r_ofw;
  assign bus.CFO_PC_busy = r_busy;
  assign bus.CFO_PC_done = r_done;

endmodule

// File: tb/tb_mul_seq.sv
// Testbench for mul_seq: randomized and directed operations against a 64-bit arithmetic
// reference model, with a scoreboard queue drained by a monitor on every done pulse.
module tb_mul_seq;
  import mul_seq_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        ofw;
    int          doneCycle;
  } exp_t;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;
  int   cycleCount;
  exp_t scb[$];
  logic [31:0] lastRes;
  logic        lastOfw;

  mul_seq_if bus();

  mul_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count active edges so completion latency can be checked against acceptance
  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard time limit so a stuck design can never hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  // Record one comparison, reporting any difference
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference product computed with plain 64-bit arithmetic
  function automatic void refModel(input logic [5:0] uop, input logic [31:0] rs, input logic [31:0] rt,
                                   output logic [31:0] res, output logic ofw);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      p;
    logic [63:0] pu;
    sa  = longint'($signed(rs));
    sb  = longint'($signed(rt));
    ub  = longint'({32'b0, rt});
    res = '0;
    ofw = 1'b0;
    case (uop)
      UOP_MUL: begin
        p   = sa * sb;
        res = p[31:0];
        ofw = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
      UOP_MULH: begin
        p   = sa * sb;
        res = p[63:32];
      end
      UOP_MULHSU: begin
        p   = sa * ub;
        res = p[63:32];
      end
      UOP_MULHU: begin
        pu  = {32'b0, rs} * {32'b0, rt};
        res = pu[63:32];
      end
      default: begin
        res = '0;
        ofw = 1'b0;
      end
    endcase
  endfunction

  // Issue one operation at a negedge; if it is expected to complete, queue its response
  task automatic applyStimulus(input logic [5:0] uop, input logic [31:0] rs, input logic [31:0] rt,
                               input bit expectDone);
    exp_t e;
    bus.DFI_PD_uops = uop;
    bus.DFI_PD_rs   = rs;
    bus.DFI_PD_rt   = rt;
    bus.CFI_PC_ena  = 1'b1;
    @(posedge clk);
    #1;
    bus.CFI_PC_ena = 1'b0;
    if (expectDone) begin
      refModel(uop, rs, rt, e.res, e.ofw);
      e.doneCycle = cycleCount + 34;
      scb.push_back(e);
      lastRes = e.res;
      lastOfw = e.ofw;
    end
    checkOutput("busy_after_accept", {63'b0, bus.CFO_PC_busy}, 64'd1);
  endtask

  // Run one complete operation and wait past its completion
  task automatic runOp(input logic [5:0] uop, input logic [31:0] rs, input logic [31:0] rt);
    applyStimulus(uop, rs, rt, 1'b1);
    repeat (36) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation, on time
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && bus.CFO_PC_done === 1'b1) begin
      if (scb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = scb.pop_front();
        checkOutput("result", {32'b0, bus.DFO_PD_rs}, {32'b0, e.res});
        checkOutput("ofw", {63'b0, bus.DFO_PD_ofw}, {63'b0, e.ofw});
        checkOutput("done_latency", 64'(cycleCount), 64'(e.doneCycle));
      end
    end
  end

  initial begin
    logic [5:0]  uop;
    logic [31:0] rs;
    logic [31:0] rt;
    tests = 0;
    fails = 0;
    lastRes = '0;
    lastOfw = 1'b0;
    bus.DFI_PD_uops  = '0;
    bus.DFI_PD_rs    = '0;
    bus.DFI_PD_rt    = '0;
    bus.CFI_PC_ena   = 1'b0;
    bus.CFI_PC_clear = 1'b0;

    // Asynchronous reset: outputs cleared without a clock edge
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("reset_result", {32'b0, bus.DFO_PD_rs}, 64'd0);
    checkOutput("reset_ofw", {63'b0, bus.DFO_PD_ofw}, 64'd0);
    checkOutput("reset_busy", {63'b0, bus.CFO_PC_busy}, 64'd0);
    checkOutput("reset_done", {63'b0, bus.CFO_PC_done}, 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Directed corner products
    runOp(UOP_MUL,    32'd7,          32'd6);
    runOp(UOP_MULH,   32'h8000_0000,  32'h8000_0000);
    runOp(UOP_MUL,    32'h8000_0000,  32'h8000_0000);
    runOp(UOP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    runOp(UOP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF);
    runOp(UOP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    runOp(UOP_MULH,   32'hFFFF_FFFD,  32'd5);
    runOp(UOP_MUL,    32'hFFFF_FFFD,  32'd5);
    runOp(UOP_DIV,    32'd100,        32'd7);

    // Clear together with ena in IDLE must not start an operation
    bus.CFI_PC_ena   = 1'b1;
    bus.CFI_PC_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.CFI_PC_ena   = 1'b0;
    bus.CFI_PC_clear = 1'b0;
    checkOutput("clear_ena_no_start", {63'b0, bus.CFO_PC_busy}, 64'd0);
    @(negedge clk);

    // ena held high: acceptances land exactly 35 edges apart; operands change after each accept
    uop = UOP_MULH;
    rs  = $urandom;
    rt  = $urandom;
    bus.DFI_PD_uops = uop;
    bus.DFI_PD_rs   = rs;
    bus.DFI_PD_rt   = rt;
    bus.CFI_PC_ena  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (i > 0) repeat (34) @(posedge clk);
      @(posedge clk);
      #1;
      refModel(uop, rs, rt, e.res, e.ofw);
      e.doneCycle = cycleCount + 34;
      scb.push_back(e);
      lastRes = e.res;
      lastOfw = e.ofw;
      rs = $urandom;
      rt = $urandom;
      bus.DFI_PD_rs = rs;
      bus.DFI_PD_rt = rt;
    end
    bus.CFI_PC_ena = 1'b0;
    repeat (36) @(negedge clk);

    // Clear during the 10th iteration: no done, previous result and flag held
    runOp(UOP_MUL, 32'h0001_0000, 32'h0001_0000);
    applyStimulus(UOP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (11) @(negedge clk);
    bus.CFI_PC_clear = 1'b1;
    @(negedge clk);
    bus.CFI_PC_clear = 1'b0;
    checkOutput("clear_busy", {63'b0, bus.CFO_PC_busy}, 64'd0);
    checkOutput("clear_held_result", {32'b0, bus.DFO_PD_rs}, {32'b0, lastRes});
    checkOutput("clear_held_ofw", {63'b0, bus.DFO_PD_ofw}, {63'b0, lastOfw});
    repeat (40) @(negedge clk);
    checkOutput("clear_held_result_late", {32'b0, bus.DFO_PD_rs}, {32'b0, lastRes});
    runOp(UOP_MULHSU, 32'h8765_4321, 32'hDEAD_BEEF);

    // Reset mid-operation: immediate clear, nothing completes afterwards
    applyStimulus(UOP_MULH, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 1'b0);
    repeat (15) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midreset_result", {32'b0, bus.DFO_PD_rs}, 64'd0);
    checkOutput("midreset_ofw", {63'b0, bus.DFO_PD_ofw}, 64'd0);
    checkOutput("midreset_busy", {63'b0, bus.CFO_PC_busy}, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lastRes = '0;
    lastOfw = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("midreset_idle_busy", {63'b0, bus.CFO_PC_busy}, 64'd0);
    runOp(UOP_MUL, 32'd0, 32'h8000_0000);

    // Randomized operations with occasional corner operands and foreign uops
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 4))
        0: uop = UOP_MUL;
        1: uop = UOP_MULH;
        2: uop = UOP_MULHSU;
        3: uop = UOP_MULHU;
        default: uop = UOP_REMU;
      endcase
      case ($urandom_range(0, 5))
        0: rs = 32'h8000_0000;
        1: rs = 32'hFFFF_FFFF;
        2: rs = 32'd0;
        default: rs = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rt = 32'h8000_0000;
        1: rt = 32'hFFFF_FFFF;
        2: rt = 32'd1;
        default: rt = $urandom;
      endcase
      runOp(uop, rs, rt);
    end

    // Every queued expectation must have been consumed by a done pulse
    checkOutput("scoreboard_empty", 64'(scb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
